ram_req_arbiter: RTL and testbench
==================================

# ram_req_arbiter

Two-requester arbiter and command sequencer for the single-port synchronous RAM. It accepts whole read/write transactions from two independent requesters, for example the SPI slave path and a host/BIST port. Each transaction is translated into the RAM's two-word command protocol (`{op[1:0], payload}` on `din`, qualified by `rx_valid`). Read data is returned to the requester that issued the read. Requesters are served one at a time, with round-robin fairness.

## Interface
- `ADDR_SIZE`, default 8: RAM address and data width. The command word is `ADDR_SIZE+2` bits.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req0`, `req1`  in  1: transaction request. Held high, with fields stable, until the matching `ack`.
- `we0`, `we1`  in  1: 1 selects write, 0 selects read.
- `addr0`, `addr1`  in  ADDR_SIZE: RAM address.
- `wdata0`, `wdata1`  in  ADDR_SIZE: write data. Ignored for reads.
- `ack0`, `ack1`  out  1: one-cycle completion pulse.
- `rdata0`, `rdata1`  out  ADDR_SIZE: read data. Valid while the matching `ack` is high; holds its value until the next read for that requester.
- `busy`  out  1: high in every state except IDLE.
- `ram_din`  out  ADDR_SIZE+2: command word to the RAM.
- `ram_rx_valid`  out  1: command strobe to the RAM.
- `ram_dout`  in  ADDR_SIZE: RAM read data.
- `ram_tx_valid`  in  1: RAM read-data valid.
- `rd_err`  out  1: one-cycle pulse, issued with `ack`, when `ram_tx_valid` was low at read capture.

## Operation
- **States:** IDLE, ADDR, DATA, RWAIT, DONE. A 1-bit `owner` register and a 1-bit `last` round-robin pointer are kept alongside the state.
- **IDLE:**
  - If exactly one `req` is high, grant it.
  - If both are high, grant the requester not equal to `last`.
  - On grant: latch `we`, `addr`, `wdata` into internal registers, set `owner`, and go to ADDR.
  - If no request is high, stay in IDLE.
- **ADDR:** `ram_rx_valid`=1. `ram_din`={2'b00, addr} for a write, {2'b10, addr} for a read. Next state is DATA.
- **DATA:** `ram_rx_valid`=1. `ram_din`={2'b01, wdata} for a write, {2'b11, 0} for a read. Next state is DONE for a write, RWAIT for a read.
- **RWAIT:** `ram_rx_valid`=0. The RAM output registered at the end of DATA is now valid.
  - Capture `ram_dout` into `rdata[owner]`.
  - If `ram_tx_valid` is 0, set the error flag.
  - Next state is DONE.
- **DONE:**
  - `ack[owner]`=1 for exactly one cycle; `rd_err` is driven from the error flag.
  - Set `last`=`owner` and clear the error flag.
  - Next state is IDLE.
- **Request handshake:** the requester deasserts `req` in the cycle `ack` is high. A `req` still high in the following IDLE cycle is a new transaction.
- **Non-owner requester:** its `req` and fields are ignored until it is granted. Its `ack` stays 0.
- **Latched fields:** changes to the owner's `addr`/`wdata` after the grant have no effect on the transaction in flight.
- **Command strobe and word:** `ram_rx_valid` is 0 in IDLE, RWAIT and DONE. `ram_din` is 0 whenever `ram_rx_valid` is 0.
- **Output decode:** all outputs are decoded from registers only (state, latched fields, `rdata`). There are no combinational paths from `req*` to outputs.
- **Reset:** asynchronous reset forces IDLE, `owner`=0, `last`=1 (so requester 0 wins the first tie), and clears the error flag. All outputs become 0, including `rdata0` and `rdata1`.
- **Reset mid-transaction:** the transaction is abandoned with no `ack`. A partially issued write may leave the RAM's internal address register updated with no data written; this is acceptable.

## Timing
- Write latency: `req` first seen in IDLE at cycle T. ADDR is at T+1, DATA at T+2, `ack` at T+3. 4 cycles per write including IDLE.
- Read latency: ADDR at T+1, DATA at T+2, RWAIT at T+3, `ack` plus `rdata` at T+4. 5 cycles per read.
- Minimum gap between transactions: one IDLE cycle after every DONE.
- Simultaneous requests: the loser is granted in the IDLE cycle immediately after the winner's DONE.
- Sustained contention alternates 0,1,0,1,…
- `busy` is high from T+1 through DONE inclusive.

## Test plan
- **Reset values:** assert `rst_n`=0 asynchronously mid-cycle. All outputs must be 0 immediately; after release, stay in IDLE with `busy`=0.
- **Single write/read, requester 0:**
  - Write addr 0x3C, data 0xA5. `ram_din` must show 0x03C then 0x1A5 on consecutive cycles; `ack0` at T+3.
  - Then read addr 0x3C. `ram_din` must show 0x23C then 0x300; `ack0` at T+4 with `rdata0`=0xA5 and `rd_err`=0.
- **Simultaneous requests from reset:**
  - `req0` writes 0x11 to address 0x01; `req1` writes 0x22 to address 0x02, both raised in the same cycle.
  - Requester 0 must complete first. Requester 1's ADDR phase must follow one IDLE cycle later.
  - Readback must give 0x11 at address 0x01 and 0x22 at address 0x02.
- **Sustained contention:** both requesters hold `req` high and re-request on every `ack` for 6 transactions. Grants must alternate 0,1,0,1,0,1, and `ack1` must never coincide with `ack0`.
- **Field changes after grant:** change `addr1` from 0x10 to 0x20 one cycle after `req1` is granted. The RAM command must still use 0x10.
- **Reset during read:** assert reset in RWAIT. There must be no `ack`, and the block must return to IDLE. A subsequent read of a previously written location must return the correct data.

Source files
------------

// File: rtl/ram_req_arbiter.sv
// ---------------------------------------------------------------------------
// ram_req_arbiter
//
// Purpose: arbitrates whole read/write transactions from two requesters and
// turns each one into the RAM's two-word command sequence
// ({op[1:0], payload} on ram_din, qualified by ram_rx_valid). Requesters are
// served one at a time with round-robin fairness. Read data is routed back
// to the requester that issued the read.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   reqN, weN             request and write(1)/read(0) select, N = 0/1
//   addrN, wdataN         transaction address and write data
//   ackN                  one-cycle completion pulse
//   rdataN                read data, held until the next read for that port
//   busy                  high whenever the sequencer is not idle
//   ram_din, ram_rx_valid command word and strobe to the RAM
//   ram_dout, ram_tx_valid read data and its valid flag from the RAM
//   rd_err                pulses with ack when ram_tx_valid was low at capture
// ---------------------------------------------------------------------------
module ram_req_arbiter #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [ADDR_SIZE-1:0] wdata0,
  input  logic [ADDR_SIZE-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [ADDR_SIZE-1:0] rdata0,
  output logic [ADDR_SIZE-1:0] rdata1,
  output logic                 busy,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 rd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RWAIT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;
  logic                   we_q, we_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [ADDR_SIZE-1:0]   wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0]   rdata0_q, rdata0_d;
  logic [ADDR_SIZE-1:0]   rdata1_q, rdata1_d;
  logic                   ack0_q, ack0_d;
  logic                   ack1_q, ack1_d;
  logic                   busy_q, busy_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rd_err_q, rd_err_d;
  logic [ADDR_SIZE+1:0]   din_q, din_d;
  logic                   grant;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    err_d    = err_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // On a tie the requester that was not served last wins; otherwise
    // whichever single request is present (req1 alone -> 1, req0 alone -> 0).
    grant    = (req0 && req1) ? ~last_q : req1;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = grant;
          we_d    = grant ? we1    : we0;
          addr_d  = grant ? addr1  : addr0;
          wdata_d = grant ? wdata1 : wdata0;
          state_d = S_ADDR;
        end
      end
      S_ADDR:  state_d = S_DATA;
      S_DATA:  state_d = we_q ? S_DONE : S_RWAIT;
      S_RWAIT: begin
        // RAM registered its output at the end of DATA; it is valid now.
        if (owner_q) rdata1_d = ram_dout;
        else         rdata0_d = ram_dout;
        err_d   = ~ram_tx_valid;
        state_d = S_DONE;
      end
      S_DONE: begin
        last_d  = owner_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: decode them from the next-cycle values so the
    // registered outputs line up with the state they describe.
    rx_valid_d = (state_d == S_ADDR) || (state_d == S_DATA);
    din_d      = '0;
    if (state_d == S_ADDR) begin
      din_d = {(we_d ? 2'b00 : 2'b10), addr_d};
    end else if (state_d == S_DATA) begin
      din_d = we_d ? {2'b01, wdata_d} : {2'b11, {ADDR_SIZE{1'b0}}};
    end
    ack0_d   = (state_d == S_DONE) && !owner_d;
    ack1_d   = (state_d == S_DONE) &&  owner_d;
    rd_err_d = (state_d == S_DONE) &&  err_d;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;   // requester 0 wins the first tie
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      err_q      <= err_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rd_err_q   <= rd_err_d;
      din_q      <= din_d;
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign busy         = busy_q;
  assign ram_din      = din_q;
  assign ram_rx_valid = rx_valid_q;
  assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_ram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_req_arbiter
//
// Directed bench for ram_req_arbiter with a behavioural model of the
// single-port RAM command protocol: op 00 latches the write address, 01
// writes data, 10 latches the read address, 11 registers mem[raddr] onto
// ram_dout with ram_tx_valid for one cycle.
// ---------------------------------------------------------------------------
module tb_ram_req_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, busy, ram_rx_valid, rd_err;
  logic [7:0] rdata0, rdata1;
  logic [9:0] ram_din;
  logic [7:0] ram_dout = '0;
  logic       ram_tx_valid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit suppress_tx = 1'b0;

  always #5 clk = ~clk;

  ram_req_arbiter #(.ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .rd_err(rd_err)
  );

  // RAM model
  logic [7:0] mem [256];
  logic [7:0] ram_wa = '0, ram_ra = '0;
  always @(posedge clk) begin
    ram_tx_valid <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: ram_wa <= ram_din[7:0];
        2'b01: mem[ram_wa] <= ram_din[7:0];
        2'b10: ram_ra <= ram_din[7:0];
        default: begin
          ram_dout     <= mem[ram_ra];
          ram_tx_valid <= !suppress_tx;
        end
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle asynchronous reset; outputs must clear immediately.
  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_val({tag, ".outs"},
              {11'd0, ack0, ack1, busy, ram_rx_valid, rd_err, ram_din, rdata0, rdata1}, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    $display("reset %s done", tag);
  endtask

  // One transaction from a single requester; DUT must be idle on entry.
  // chg moves the requester's address (a ^ 0x30) one cycle after the grant.
  task automatic run_txn(input string tag, input bit who, input bit we,
                         input logic [7:0] a, input logic [7:0] d,
                         input logic [9:0] e0, input logic [9:0] e1,
                         input logic [7:0] erd, input bit eerr, input bit chg);
    logic [9:0] cmd0, cmd1;
    logic [7:0] rd;
    int k, lat;
    bit other, err_seen;
    k = 0; lat = -1; other = 1'b0; err_seen = 1'b0; rd = '0; cmd0 = '0; cmd1 = '0;
    @(posedge clk); #1;
    if (!who) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else      begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ram_rx_valid) begin
        if (k == 0) cmd0 = ram_din;
        else if (k == 1) cmd1 = ram_din;
        k++;
      end
      if (chg && n == 1) begin
        if (!who) addr0 = a ^ 8'h30; else addr1 = a ^ 8'h30;
      end
      if (who ? ack0 : ack1) other = 1'b1;
      if (who ? ack1 : ack0) begin
        lat = n; err_seen = rd_err; rd = who ? rdata1 : rdata0;
        break;
      end
    end
    if (!who) req0 = 1'b0; else req1 = 1'b0;
    check_val({tag, ".cmd0"}, {22'd0, cmd0}, {22'd0, e0});
    check_val({tag, ".cmd1"}, {22'd0, cmd1}, {22'd0, e1});
    check_val({tag, ".lat"}, lat, we ? 32'd3 : 32'd4);
    check_val({tag, ".other_ack"}, {31'd0, other}, 32'd0);
    check_val({tag, ".rd_err"}, {31'd0, err_seen}, {31'd0, eerr});
    if (!we) check_val({tag, ".rdata"}, {24'd0, rd}, {24'd0, erd});
    $display("txn %s who=%0d we=%0d addr=%02h cmd=%03h,%03h lat=%0d rdata=%02h err=%0b",
             tag, who, we, a, cmd0, cmd1, lat, rd, err_seen);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int ack0_n, ack1_n, a1_n, cnt;
    bit coinc;
    int ord [6];

    do_reset("init");

    // Single write then read, requester 0
    run_txn("wr0", 1'b0, 1'b1, 8'h3C, 8'hA5, 10'h03C, 10'h1A5, 8'h00, 1'b0, 1'b0);
    run_txn("rd0", 1'b0, 1'b0, 8'h3C, 8'h00, 10'h23C, 10'h300, 8'hA5, 1'b0, 1'b0);

    // rdata0 is non-zero here, so the reset must visibly clear it
    do_reset("mid");

    // Simultaneous requests straight out of reset
    ack0_n = -1; ack1_n = -1; a1_n = -1; coinc = 1'b0;
    @(posedge clk); #1;
    we0 = 1'b1; addr0 = 8'h01; wdata0 = 8'h11;
    we1 = 1'b1; addr1 = 8'h02; wdata1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack0 && ack1) coinc = 1'b1;
      if (ram_rx_valid && ram_din == 10'h002 && a1_n < 0) a1_n = n;
      if (ack0) begin ack0_n = n; req0 = 1'b0; end
      if (ack1) begin ack1_n = n; req1 = 1'b0; break; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check_val("sim.ack0_cyc", ack0_n, 32'd3);
    check_val("sim.addr1_cyc", a1_n, 32'd5);
    check_val("sim.ack1_cyc", ack1_n, 32'd7);
    check_val("sim.coincide", {31'd0, coinc}, 32'd0);
    $display("txn sim ack0@%0d addr1@%0d ack1@%0d", ack0_n, a1_n, ack1_n);
    run_txn("rb1", 1'b0, 1'b0, 8'h01, 8'h00, 10'h201, 10'h300, 8'h11, 1'b0, 1'b0);
    run_txn("rb2", 1'b1, 1'b0, 8'h02, 8'h00, 10'h202, 10'h300, 8'h22, 1'b0, 1'b0);

    // Sustained contention from reset: expect 0,1,0,1,0,1
    do_reset("cont");
    cnt = 0; coinc = 1'b0;
    for (int i = 0; i < 6; i++) ord[i] = -1;
    @(posedge clk); #1;
    we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'hA0;
    we1 = 1'b1; addr1 = 8'h41; wdata1 = 8'hB1;
    req0 = 1'b1; req1 = 1'b1;
    for (int n = 0; n < 60 && cnt < 6; n++) begin
      @(negedge clk);
      if (ack0 && ack1) coinc = 1'b1;
      if (ack0) begin ord[cnt] = 0; cnt++; end
      else if (ack1) begin ord[cnt] = 1; cnt++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check_val("cont.count", cnt, 32'd6);
    check_val("cont.coincide", {31'd0, coinc}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("cont.grant%0d", i), ord[i], i % 2);
      $display("txn cont #%0d owner=%0d", i, ord[i]);
    end
    repeat (2) @(negedge clk);

    // Field change after grant: command must keep address 0x10
    run_txn("pre20", 1'b0, 1'b1, 8'h20, 8'h77, 10'h020, 10'h177, 8'h00, 1'b0, 1'b0);
    run_txn("fld", 1'b1, 1'b1, 8'h10, 8'h5A, 10'h010, 10'h15A, 8'h00, 1'b0, 1'b1);
    run_txn("rb10", 1'b1, 1'b0, 8'h10, 8'h00, 10'h210, 10'h300, 8'h5A, 1'b0, 1'b0);
    run_txn("rb20", 1'b0, 1'b0, 8'h20, 8'h00, 10'h220, 10'h300, 8'h77, 1'b0, 1'b0);

    // RAM fails to raise tx_valid: rd_err pulses with ack
    suppress_tx = 1'b1;
    run_txn("rderr", 1'b0, 1'b0, 8'h3C, 8'h00, 10'h23C, 10'h300, 8'hA5, 1'b1, 1'b0);
    suppress_tx = 1'b0;

    // Reset during RWAIT: no ack, back to idle, data intact afterwards
    coinc = 1'b0;
    @(posedge clk); #1;
    we0 = 1'b0; addr0 = 8'h3C; req0 = 1'b1;
    for (int n = 0; n < 3; n++) @(negedge clk);
    @(negedge clk);  // RWAIT: busy, no strobe
    check_val("rst_rw.state", {30'd0, busy, ram_rx_valid}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_rw.outs", {13'd0, ack0, ack1, busy, rd_err, rdata0, rdata1}, 32'd0);
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack0 || ack1) coinc = 1'b1;
    end
    check_val("rst_rw.no_ack", {31'd0, coinc}, 32'd0);
    check_val("rst_rw.idle", {31'd0, busy}, 32'd0);
    $display("txn rst_rw reset in RWAIT, ack_seen=%0b", coinc);
    run_txn("rd_after", 1'b0, 1'b0, 8'h3C, 8'h00, 10'h23C, 10'h300, 8'hA5, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
